// File: rtl/data_mem_pkg.sv
// Shared types and default constants for the data memory with its hardware preload sequencer.
package data_mem_pkg;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} dm_state_t;

    localparam int         DM_W            = 8;
    localparam int         DM_A            = 8;
    localparam int         DM_PRELOAD_BASE = 128;
    localparam int         DM_SPACE_ADDR   = 255;
    localparam logic [7:0] DM_SPACE_VAL    = 8'h20;

endpackage

// File: rtl/data_mem_init_seq.sv
// Post-reset preload walker: clears [PRELOAD_BASE, 2**A-1] and plants SPACE_VAL at SPACE_ADDR.
module data_mem_init_seq
    import data_mem_pkg::*;
#(
    parameter int             W            = DM_W,
    parameter int             A            = DM_A,
    parameter int             PRELOAD_BASE = DM_PRELOAD_BASE,
    parameter int             SPACE_ADDR   = DM_SPACE_ADDR,
    parameter logic [W-1:0]   SPACE_VAL    = W'(DM_SPACE_VAL)
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              InitWe,
    output logic [A-1:0]      InitAddr,
    output logic [W-1:0]      InitData,
    output logic              Busy,
    output dm_state_t         State
);

    // One spare MSB keeps the terminal compare at 2**A-1 from aliasing onto address 0.
    localparam logic [A:0] BASE_PTR  = PRELOAD_BASE[A:0];
    localparam logic [A:0] LAST_PTR  = {1'b0, {A{1'b1}}};
    localparam logic [A:0] SPACE_PTR = SPACE_ADDR[A:0];
    localparam logic [A:0] PTR_ONE   = {{A{1'b0}}, 1'b1};

    dm_state_t    state, state_next;
    logic [A:0]   init_ptr, ptr_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= INIT;
            init_ptr <= BASE_PTR;
        end else begin
            state    <= state_next;
            init_ptr <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = init_ptr;
        InitWe     = 1'b0;
        InitAddr   = init_ptr[A-1:0];
        InitData   = '0;
        case (state)
            INIT: begin
                InitWe   = ~Reset;
                InitData = (init_ptr == SPACE_PTR) ? SPACE_VAL : '0;
                ptr_next = init_ptr + PTR_ONE;
                if (init_ptr == LAST_PTR)
                    state_next = RUN;
            end
            RUN: ;
            default: state_next = INIT;
        endcase
    end

    assign Busy  = Reset | (state == INIT);
    assign State = state;

endmodule

// File: rtl/data_mem_seq.sv
// Single-write-port byte data memory with hardware preload and selectable read latency.
// Optional build macro DATAMEM_CONST_PROTECT_EN makes SPACE_ADDR read-only in RUN and raises Fault.
module data_mem_seq
    import data_mem_pkg::*;
#(
    parameter int             W            = DM_W,
    parameter int             A            = DM_A,
    parameter int             PRELOAD_BASE = DM_PRELOAD_BASE,
    parameter int             SPACE_ADDR   = DM_SPACE_ADDR,
    parameter logic [W-1:0]   SPACE_VAL    = W'(DM_SPACE_VAL),
    parameter int             READ_LAT     = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WriteEn,
    input  logic              ReadEn,
    input  logic [A-1:0]      DataAddress,
    input  logic [W-1:0]      DataIn,
    output logic [W-1:0]      DataOut,
    output logic              ReadValid,
    output logic              Busy,
    output logic              Fault
);

    if (READ_LAT != 0 && READ_LAT != 1) begin : g_bad_lat
        $error("data_mem_seq: READ_LAT must be 0 or 1");
    end
    if (PRELOAD_BASE >= 2**A || SPACE_ADDR < PRELOAD_BASE || SPACE_ADDR > 2**A - 1) begin : g_bad_map
        $error("data_mem_seq: PRELOAD_BASE/SPACE_ADDR outside the address map");
    end

    logic [W-1:0] core [2**A];

    logic         init_we;
    logic [A-1:0] init_addr;
    logic [W-1:0] init_data;
    dm_state_t    unused_init_state;

    data_mem_init_seq #(
        .W            (W),
        .A            (A),
        .PRELOAD_BASE (PRELOAD_BASE),
        .SPACE_ADDR   (SPACE_ADDR),
        .SPACE_VAL    (SPACE_VAL)
    ) u_init_seq (
        .Clk      (Clk),
        .Reset    (Reset),
        .InitWe   (init_we),
        .InitAddr (init_addr),
        .InitData (init_data),
        .Busy     (Busy),
        .State    (unused_init_state)
    );

    logic         protect_hit;
    logic         user_we;
    logic         array_we;
    logic [A-1:0] array_addr;
    logic [W-1:0] array_data;

`ifdef DATAMEM_CONST_PROTECT_EN
    logic fault_q;

    assign protect_hit = (DataAddress == SPACE_ADDR[A-1:0]);

    always_ff @(posedge Clk) begin
        if (Reset)
            fault_q <= 1'b0;
        else if (WriteEn && !Busy && protect_hit)
            fault_q <= 1'b1;
    end

    assign Fault = fault_q;
`else
    assign protect_hit = 1'b0;
    assign Fault       = 1'b0;
`endif

    // Init and user writes are mutually exclusive: init only runs while Busy, user only when idle.
    assign user_we    = WriteEn & ~Busy & ~protect_hit;
    assign array_we   = init_we | user_we;
    assign array_addr = init_we ? init_addr : DataAddress;
    assign array_data = init_we ? init_data : DataIn;

    always_ff @(posedge Clk) begin
        if (array_we)
            core[array_addr] <= array_data;
    end

    if (READ_LAT == 1) begin : g_reg_read
        logic [W-1:0] dout_q;
        logic         rvalid_q;

        // Sampled at the same edge as any write, so a same-address read returns the old value.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                dout_q   <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= ReadEn & ~Busy;
                if (ReadEn && !Busy)
                    dout_q <= core[DataAddress];
            end
        end

        assign DataOut   = dout_q;
        assign ReadValid = rvalid_q;
    end else begin : g_comb_read
        logic unused_read_en;

        assign unused_read_en = ReadEn;
        assign DataOut        = core[DataAddress];
        assign ReadValid      = ~Busy;
    end

endmodule

// File: tb/tb_data_mem_seq.sv
// Directed bench for data_mem_seq: default comb-read, registered-read and small-geometry instances.
module tb_data_mem_seq;

    logic       Clk = 1'b0;
    logic       Reset;

    logic       we0, re0, rv0, busy0, fault0;
    logic [7:0] addr0, din0, dout0;
    logic       we1, re1, rv1, busy1, fault1;
    logic [7:0] addr1, din1, dout1;
    logic       we2, re2, rv2, busy2, fault2;
    logic [3:0] addr2;
    logic [7:0] din2, dout2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    data_mem_seq #(.READ_LAT(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .WriteEn(we0), .ReadEn(re0), .DataAddress(addr0),
        .DataIn(din0), .DataOut(dout0), .ReadValid(rv0), .Busy(busy0), .Fault(fault0)
    );

    data_mem_seq #(.READ_LAT(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .WriteEn(we1), .ReadEn(re1), .DataAddress(addr1),
        .DataIn(din1), .DataOut(dout1), .ReadValid(rv1), .Busy(busy1), .Fault(fault1)
    );

    data_mem_seq #(.A(4), .PRELOAD_BASE(8), .SPACE_ADDR(15), .READ_LAT(0)) dut2 (
        .Clk(Clk), .Reset(Reset), .WriteEn(we2), .ReadEn(re2), .DataAddress(addr2),
        .DataIn(din2), .DataOut(dout2), .ReadValid(rv2), .Busy(busy2), .Fault(fault2)
    );

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Counts cycles each instance reports Busy until all three are idle (bounded).
    task automatic count_busy(output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(busy0 || busy1 || busy2)) break;
            c0 += int'(busy0);
            c1 += int'(busy1);
            c2 += int'(busy2);
            tick();
        end
        check("all_idle_within_bound", {29'd0, busy0, busy1, busy2}, 32'd0);
    endtask

    initial begin
        int c0, c1, c2;
        logic [7:0] exp255;
        logic       exp_fault;

`ifdef DATAMEM_CONST_PROTECT_EN
        exp255    = 8'h20;
        exp_fault = 1'b1;
`else
        exp255    = 8'h00;
        exp_fault = 1'b0;
`endif

        Reset = 1'b1;
        we0 = 0; re0 = 0; addr0 = 0; din0 = 0;
        we1 = 0; re1 = 0; addr1 = 0; din1 = 0;
        we2 = 0; re2 = 0; addr2 = 0; din2 = 0;
        tick();
        tick();

        check("reset_busy",      {29'd0, busy0, busy1, busy2}, 32'h7);
        check("reset_readvalid", {29'd0, rv0, rv1, rv2},       32'h0);
        check("reset_fault",     {29'd0, fault0, fault1, fault2}, 32'h0);
        check("reset_dout_reg",  dout1, 8'h00);

        Reset = 1'b0;
        #1;
        count_busy(c0, c1, c2);
        check("init_len_default", c0, 128);
        check("init_len_reglat",  c1, 128);
        check("init_len_small",   c2, 8);

        // Seed low memory, which must survive later resets.
        we0 = 1; addr0 = 8'h05; din0 = 8'h5A;
        we1 = 1; addr1 = 8'h40; din1 = 8'h11;
        tick();
        addr0 = 8'h10; din0 = 8'h33;
        addr1 = 8'h90; din1 = 8'h77;
        tick();
        addr0 = 8'h90; din0 = 8'h77;
        tick();
        we0 = 0; we1 = 0;

        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        count_busy(c0, c1, c2);
        check("reinit_len_default", c0, 128);

        vecs.push_back('{1'b0, 8'd128, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 8'd200, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 8'd255, 8'h00, 8'h20, 1'b1});
        vecs.push_back('{1'b0, 8'h90,  8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 8'd5,   8'h00, 8'h5A, 1'b1});
        vecs.push_back('{1'b1, 8'h10,  8'hA5, 8'h33, 1'b1});
        vecs.push_back('{1'b0, 8'h10,  8'h00, 8'hA5, 1'b1});
        vecs.push_back('{1'b1, 8'd200, 8'h3C, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 8'd200, 8'h00, 8'h3C, 1'b1});
        vecs.push_back('{1'b0, 8'h7F,  8'h00, 8'h00, 1'b1});

        foreach (vecs[i]) begin
            we0 = vecs[i].we; addr0 = vecs[i].addr; din0 = vecs[i].din;
            #1;
            check($sformatf("vec%0d_dout", i), dout0, vecs[i].exp_dout);
            check($sformatf("vec%0d_valid", i), rv0, vecs[i].exp_valid);
            tick();
            we0 = 0;
        end

        // Registered read: same-cycle read and write of one address returns the old byte.
        addr1 = 8'h40; din1 = 8'h22; we1 = 1; re1 = 1;
        tick();
        we1 = 0; re1 = 0;
        check("rl1_read_first_dout",  dout1, 8'h11);
        check("rl1_read_first_valid", rv1, 1'b1);
        re1 = 1;
        tick();
        re1 = 0;
        check("rl1_new_dout", dout1, 8'h22);
        check("rl1_new_valid", rv1, 1'b1);
        addr1 = 8'hFF;
        tick();
        check("rl1_hold_dout", dout1, 8'h22);
        check("rl1_idle_valid", rv1, 1'b0);
        re1 = 1;
        tick();
        re1 = 0;
        check("rl1_space_dout", dout1, 8'h20);

        addr2 = 4'd15;
        #1;
        check("small_space_val", dout2, 8'h20);
        addr2 = 4'd8;
        #1;
        check("small_base_zero", dout2, 8'h00);
        check("small_run_valid", rv2, 1'b1);

        // Store to the space slot in RUN.
        we0 = 1; addr0 = 8'hFF; din0 = 8'h00;
        tick();
        we0 = 0;
        #1;
        check("space_write_data", dout0, exp255);
        check("space_write_fault", fault0, exp_fault);
        tick();
        check("space_fault_sticky", fault0, exp_fault);

        // Restart, then reassert Reset 60 cycles into init for 3 cycles while storing to 0x90.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        c0 = 0;
        for (int i = 0; i < 400; i++) begin
            Reset = (c0 < 3);
            we0   = (c0 < 3) || (c0 >= 30 && c0 < 120);
            addr0 = 8'h90;
            din0  = 8'hEE;
            #1;
            if (!busy0) break;
            c0++;
            tick();
        end
        we0 = 0;
        Reset = 1'b0;
        check("midinit_busy_len", c0, 131);
        addr0 = 8'h90;
        #1;
        check("midinit_drop_write", dout0, 8'h00);
        addr0 = 8'hFF;
        #1;
        check("midinit_space_val", dout0, 8'h20);
        check("midinit_fault_cleared", fault0, 1'b0);
        addr0 = 8'h05;
        #1;
        check("low_mem_retained", dout0, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_seq.md
Name: data_mem_seq

Overview:
- Parametrised successor to the single-port byte data memory, with a multi-cycle hardware preload sequencer instead of reset-time constant writes.
- After reset, walks the upper memory region and writes the stack-pointer slot (zero) and the space-character constant.
- Offers selectable combinational or registered reads, with a Busy handshake to the core.
- Sits between the CPU datapath (load/store unit) and the memory array.

Parameters:
- W, 8, data width in bits; the CSE141L ISA requires 8.
- A, 8, address width; depth = 2**A entries.
- PRELOAD_BASE, 128, first address cleared by the init sequencer. Must be below 2**A.
- SPACE_ADDR, 255, address receiving SPACE_VAL during init. Must be in [PRELOAD_BASE, 2**A-1].
- SPACE_VAL, 8'h20, constant written at SPACE_ADDR.
- READ_LAT, 0, read latency. 0 = combinational, 1 = registered. Other values are illegal (elaboration $error).

Ports:
- Clk  in  1  single clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- WriteEn  in  1  store strobe. Honoured only when Busy=0.
- ReadEn  in  1  load strobe. Used only when READ_LAT=1; ignored when READ_LAT=0.
- DataAddress  in  A  shared read/write pointer.
- DataIn  in  W  store data.
- DataOut  out  W  load data.
- ReadValid  out  1  DataOut qualifier. Tied to ~Busy when READ_LAT=0.
- Busy  out  1  high while Reset is asserted or init is in progress.
- Fault  out  1  sticky protection violation; only present with the optional feature.

Behaviour:
- FSM states: INIT, RUN.
  - Reset=1: state<=INIT, InitPtr<=PRELOAD_BASE, no array write. Reset held N cycles keeps restarting.
  - INIT with Reset=0: each cycle writes core[InitPtr] <= (InitPtr==SPACE_ADDR) ? SPACE_VAL : 0, then InitPtr++.
  - INIT ends after writing 2**A-1; next state is RUN. Init takes 2**A-PRELOAD_BASE cycles after Reset falls (128 at defaults).
  - RUN: stays in RUN until Reset.
- Addresses below PRELOAD_BASE are never written by init and retain their contents across Reset.
- Busy is a combinational output: Busy = Reset | (state==INIT). It is 1 on the first post-reset cycle.
- Accesses while Busy=1:
  - WriteEn is dropped; no array write.
  - ReadEn is dropped; ReadValid=0 on the following cycle.
- Writes in RUN: at posedge with WriteEn=1, core[DataAddress] <= DataIn.
- Reads with READ_LAT=0:
  - DataOut = core[DataAddress] combinationally.
  - Read of an address being written that cycle shows old data until the edge, then new data.
- Reads with READ_LAT=1:
  - ReadEn=1 in RUN at edge k gives DataOut=core[DataAddress] and ReadValid=1 after edge k.
  - Read-first: a read and write to the same address in one cycle returns the pre-write value.
  - DataOut holds its last value when ReadEn=0; ReadValid=0.
- Reset values: ReadValid=0, Busy=1, Fault=0, FSM=INIT. With READ_LAT=1, the DataOut register resets to 0.
- Reset asserted mid-init: pointer returns to PRELOAD_BASE and init restarts in full after release.
- Wrap: InitPtr is A+1 bits wide so the terminal compare at 2**A-1 cannot alias to 0.

Optional Feature:
- Macro: DATAMEM_CONST_PROTECT_EN.
- Defined:
  - A RUN-state write to SPACE_ADDR is dropped; the array is unchanged.
  - Fault is set and stays 1 until Reset. Reads are unaffected.
  - Init writes are never blocked.
- Undefined: SPACE_ADDR is ordinary writable memory and Fault is tied to 0.

Decomposition:
- Package data_mem_pkg holds:
  - typedef enum logic {INIT, RUN} dm_state_t;
  - default constants DM_W, DM_A, DM_PRELOAD_BASE, DM_SPACE_ADDR, DM_SPACE_VAL.
- Sub-module data_mem_init_seq holds the FSM, InitPtr and Busy. It outputs InitWe, InitAddr and InitData.
- The top level muxes init vs. user write ports into a single-write-port array and holds the read-latency generate.

Test Plan:
- Reset 1 cycle, release, count Busy cycles -> exactly 128 cycles high. Then core[128]=0, core[200]=0, core[255]=8'h20, and core[5] keeps its pre-reset value.
- RUN, READ_LAT=0: write 8'hA5 to 8'h10, then change address back to 8'h10 -> DataOut=8'hA5 combinationally, ReadValid=1.
- READ_LAT=1: same-cycle WriteEn and ReadEn at 8'h40 (old 8'h11, new 8'h22) -> next cycle DataOut=8'h11 with ReadValid=1. A following read returns 8'h22.
- Reset asserted at init cycle 60 for 3 cycles -> Busy stays 1 continuously for 3+128 cycles from the Reset assertion. WriteEn to 8'h90 during Busy is dropped, so core[8'h90]=0 after init.
- DATAMEM_CONST_PROTECT_EN defined: RUN write 8'h00 to 255 -> core[255] stays 8'h20 and Fault=1 until next Reset. Undefined: core[255]=0 and Fault=0.
- Parameter sweep A=4, PRELOAD_BASE=8, SPACE_ADDR=15 -> init lasts 8 cycles, core[15]=8'h20, FSM reaches RUN with no pointer wrap.
